lmb_bram_arbiter: RTL and testbench

LMB_BRAM_ARBITER -- requirements
Module: lmb_bram_arbiter

---
 rtl/lmb_bram_arbiter.sv | 135 +++++++++++++
 tb/tb_lmb_bram_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmb_bram_arbiter.sv
//------------------------------------------------------------------------------
// lmb_bram_arbiter : two-requester single-port BRAM arbiter with bounded bursts
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module lmb_bram_arbiter #(
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_MAX_BURST   = 8
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst,
  input  logic                     M0_Req,
  input  logic [0:C_NUM_WE-1]      M0_WEN,
  input  logic [0:C_PORT_AWIDTH-1] M0_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M0_Wdata,
  output logic                     M0_Ack,
  output logic                     M0_RdValid,
  output logic [0:C_PORT_DWIDTH-1] M0_Rdata,
  input  logic                     M1_Req,
  input  logic [0:C_NUM_WE-1]      M1_WEN,
  input  logic [0:C_PORT_AWIDTH-1] M1_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M1_Wdata,
  output logic                     M1_Ack,
  output logic                     M1_RdValid,
  output logic [0:C_PORT_DWIDTH-1] M1_Rdata,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam logic [7:0] C_MAX_CNT = 8'(C_MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rdv0_q, rdv0_d;
  logic       rdv1_q, rdv1_d;

  logic       w_ack0;
  logic       w_ack1;
  logic [7:0] w_cnt_inc;

  // Acks are suppressed while reset is held so nothing reaches the BRAM.
  assign w_ack0    = (state_q == OWN0) & M0_Req & ~BRAM_Rst;
  assign w_ack1    = (state_q == OWN1) & M1_Req & ~BRAM_Rst;
  assign w_cnt_inc = (cnt_q == C_MAX_CNT) ? C_MAX_CNT : cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (M0_Req && M1_Req) state_d = last_owner_q ? OWN0 : OWN1;
        else if (M0_Req)      state_d = OWN0;
        else if (M1_Req)      state_d = OWN1;
      end
      OWN0: begin
        if (M0_Req) begin
          cnt_d = w_cnt_inc;
          if ((w_cnt_inc == C_MAX_CNT) && M1_Req) begin
            state_d      = OWN1;
            cnt_d        = 8'd0;
            last_owner_d = 1'b0;
          end
        end else begin
          state_d      = M1_Req ? OWN1 : IDLE;
          cnt_d        = 8'd0;
          last_owner_d = 1'b0;
        end
      end
      OWN1: begin
        if (M1_Req) begin
          cnt_d = w_cnt_inc;
          if ((w_cnt_inc == C_MAX_CNT) && M0_Req) begin
            state_d      = OWN0;
            cnt_d        = 8'd0;
            last_owner_d = 1'b1;
          end
        end else begin
          state_d      = M0_Req ? OWN0 : IDLE;
          cnt_d        = 8'd0;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdv0_d = w_ack0 & ~(|M0_WEN);
  assign rdv1_d = w_ack1 & ~(|M1_WEN);

  always_ff @(posedge BRAM_Clk) begin
    if (BRAM_Rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= 8'd0;
      rdv0_q       <= 1'b0;
      rdv1_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      rdv0_q       <= rdv0_d;
      rdv1_q       <= rdv1_d;
    end
  end

  assign M0_Ack     = w_ack0;
  assign M1_Ack     = w_ack1;
  assign M0_RdValid = rdv0_q;
  assign M1_RdValid = rdv1_q;
  assign M0_Rdata   = BRAM_Din;
  assign M1_Rdata   = BRAM_Din;

  assign BRAM_EN   = w_ack0 | w_ack1;
  assign BRAM_WEN  = w_ack0 ? M0_WEN : (w_ack1 ? M1_WEN : '0);
  assign BRAM_Addr = (state_q == OWN1) ? M1_Addr : M0_Addr;
  assign BRAM_Dout = (state_q == OWN1) ? M1_Wdata : M0_Wdata;

endmodule

`default_nettype wire

// File: tb/tb_lmb_bram_arbiter.sv
//------------------------------------------------------------------------------
// tb_lmb_bram_arbiter : randomized scoreboard bench, burst 8 and burst 1 instances
// Revision 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_lmb_bram_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NWE = 4;

  typedef struct {
    int             cyc;
    int             m;
    logic [0:NWE-1] wen;
    logic [0:AW-1]  addr;
    logic [0:DW-1]  data;
  } acc_t;

  typedef struct {
    int            cyc;
    int            m;
    logic [0:DW-1] data;
    bit            chk;
  } rd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic           req_i   [2];
  logic [0:NWE-1] wen_i   [2];
  logic [0:AW-1]  addr_i  [2];
  logic [0:DW-1]  wdata_i [2];
  logic [0:DW-1]  din;

  logic           ack_o   [2][2];
  logic           rv_o    [2][2];
  logic [0:DW-1]  rdata_o [2][2];
  logic           en_o    [2];
  logic [0:NWE-1] bwen_o  [2];
  logic [0:AW-1]  baddr_o [2];
  logic [0:DW-1]  bdout_o [2];

  lmb_bram_arbiter #(.C_PORT_DWIDTH(DW), .C_PORT_AWIDTH(AW), .C_NUM_WE(NWE), .C_MAX_BURST(8)) u_dut (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .M0_Req(req_i[0]), .M0_WEN(wen_i[0]), .M0_Addr(addr_i[0]), .M0_Wdata(wdata_i[0]),
    .M0_Ack(ack_o[0][0]), .M0_RdValid(rv_o[0][0]), .M0_Rdata(rdata_o[0][0]),
    .M1_Req(req_i[1]), .M1_WEN(wen_i[1]), .M1_Addr(addr_i[1]), .M1_Wdata(wdata_i[1]),
    .M1_Ack(ack_o[0][1]), .M1_RdValid(rv_o[0][1]), .M1_Rdata(rdata_o[0][1]),
    .BRAM_EN(en_o[0]), .BRAM_WEN(bwen_o[0]), .BRAM_Addr(baddr_o[0]), .BRAM_Dout(bdout_o[0]),
    .BRAM_Din(din)
  );

  lmb_bram_arbiter #(.C_PORT_DWIDTH(DW), .C_PORT_AWIDTH(AW), .C_NUM_WE(NWE), .C_MAX_BURST(1)) u_dut_b (
    .BRAM_Clk(clk), .BRAM_Rst(rst),
    .M0_Req(req_i[0]), .M0_WEN(wen_i[0]), .M0_Addr(addr_i[0]), .M0_Wdata(wdata_i[0]),
    .M0_Ack(ack_o[1][0]), .M0_RdValid(rv_o[1][0]), .M0_Rdata(rdata_o[1][0]),
    .M1_Req(req_i[1]), .M1_WEN(wen_i[1]), .M1_Addr(addr_i[1]), .M1_Wdata(wdata_i[1]),
    .M1_Ack(ack_o[1][1]), .M1_RdValid(rv_o[1][1]), .M1_Rdata(rdata_o[1][1]),
    .BRAM_EN(en_o[1]), .BRAM_WEN(bwen_o[1]), .BRAM_Addr(baddr_o[1]), .BRAM_Dout(bdout_o[1]),
    .BRAM_Din(din)
  );

  acc_t aq [2][$];
  rd_t  rq [2][$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   done  = 1'b0;

  // Reference model: who owns the port, run length of the current owner,
  // who owned it last, and the read issued in the previous cycle.
  int            own  [2];
  int            run  [2];
  int            last [2];
  int            mx   [2];
  int            rd_m [2];
  logic [0:AW-1] rd_a [2];
  logic [0:DW-1] mem  [16];
  bit            pend [2];
  bit            cont;

  function automatic int idx(input logic [0:AW-1] a);
    return (int'(a) >> 2) & 15;
  endfunction

  task automatic new_req(input int m);
    pend[m]    = 1'b1;
    req_i[m]   = 1'b1;
    wdata_i[m] = DW'($urandom);
    if (cont) begin
      wen_i[m]  = '0;
      addr_i[m] = AW'(m * 4);
    end else begin
      wen_i[m]  = ($urandom_range(1) == 0) ? '0 : NWE'($urandom_range(15));
      addr_i[m] = AW'($urandom_range(15) * 4);
    end
  endtask

  task automatic step(input bit r, input int p);
    int   a;
    int   n;
    int   o;
    int   acked;
    acc_t ea;
    rd_t  er;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    for (int m = 0; m < 2; m++) begin
      if (!pend[m]) begin
        if (cont || ($urandom_range(99) < p)) new_req(m);
        else req_i[m] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rd_m[k] >= 0) begin
        er.cyc  = cyc;
        er.m    = rd_m[k];
        er.data = mem[idx(rd_a[k])];
        er.chk  = (k == 0);
        rq[k].push_back(er);
      end
    end
    din   = (rd_m[0] >= 0) ? mem[idx(rd_a[0])] : DW'($urandom);
    acked = -1;
    for (int k = 0; k < 2; k++) begin
      a = -1;
      if (!r && own[k] >= 0 && req_i[own[k]]) a = own[k];
      rd_m[k] = -1;
      if (a >= 0) begin
        ea.cyc  = cyc;
        ea.m    = a;
        ea.wen  = wen_i[a];
        ea.addr = addr_i[a];
        ea.data = wdata_i[a];
        aq[k].push_back(ea);
        if (wen_i[a] == '0) begin
          rd_m[k] = a;
          rd_a[k] = addr_i[a];
        end else if (k == 0) begin
          for (int b = 0; b < NWE; b++)
            if (wen_i[a][b]) mem[idx(addr_i[a])][8*b +: 8] = wdata_i[a][8*b +: 8];
        end
        if (k == 0) acked = a;
      end
      if (r) begin
        own[k]  = -1;
        run[k]  = 0;
        last[k] = 1;
      end else if (own[k] < 0) begin
        if (req_i[0] && req_i[1]) own[k] = 1 - last[k];
        else if (req_i[0])        own[k] = 0;
        else if (req_i[1])        own[k] = 1;
      end else begin
        n = own[k];
        o = 1 - n;
        if (req_i[n]) begin
          run[k] = (run[k] + 1 > mx[k]) ? mx[k] : run[k] + 1;
          if (run[k] == mx[k] && req_i[o]) begin
            own[k]  = o;
            run[k]  = 0;
            last[k] = n;
          end
        end else begin
          own[k]  = req_i[o] ? o : -1;
          run[k]  = 0;
          last[k] = n;
        end
      end
    end
    if (acked >= 0) pend[acked] = 1'b0;
  endtask

  initial begin : monitor
    acc_t ea;
    rd_t  er;
    bit   a0, a1, v0, v1;
    forever begin
      @(negedge clk);
      if (done) break;
      for (int k = 0; k < 2; k++) begin
        a0 = ack_o[k][0];
        a1 = ack_o[k][1];
        v0 = rv_o[k][0];
        v1 = rv_o[k][1];
        n_vec++;
        if (en_o[k] !== (a0 | a1) || (a0 && a1)) begin
          n_bad++;
          $display("FAIL en_vs_ack dut%0d cyc %0d: EN=%b Ack0=%b Ack1=%b, need EN=Ack0|Ack1 one-hot",
                   k, cyc, en_o[k], a0, a1);
        end
        if (!en_o[k]) begin
          n_vec++;
          if (bwen_o[k] !== '0) begin
            n_bad++;
            $display("FAIL wen_idle dut%0d cyc %0d: BRAM_WEN=%b, need 0", k, cyc, bwen_o[k]);
          end
        end
        while (aq[k].size() > 0 && aq[k][0].cyc < cyc) begin
          ea = aq[k].pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missing_ack dut%0d cyc %0d: got no ack, expected M%0d ack", k, ea.cyc, ea.m);
        end
        if (a0 || a1) begin
          n_vec++;
          if (aq[k].size() == 0 || aq[k][0].cyc != cyc) begin
            n_bad++;
            $display("FAIL unexpected_ack dut%0d cyc %0d: got Ack0=%b Ack1=%b, expected none", k, cyc, a0, a1);
          end else begin
            ea = aq[k].pop_front();
            if (a1 != (ea.m == 1) || bwen_o[k] !== ea.wen || baddr_o[k] !== ea.addr || bdout_o[k] !== ea.data) begin
              n_bad++;
              $display("FAIL access dut%0d cyc %0d: got M%0d wen=%b addr=%h dout=%h, need M%0d wen=%b addr=%h dout=%h",
                       k, cyc, a1, bwen_o[k], baddr_o[k], bdout_o[k], ea.m, ea.wen, ea.addr, ea.data);
            end
          end
        end
        while (rq[k].size() > 0 && rq[k][0].cyc < cyc) begin
          er = rq[k].pop_front();
          n_vec++;
          n_bad++;
          $display("FAIL missing_rdvalid dut%0d cyc %0d: got none, expected M%0d RdValid", k, er.cyc, er.m);
        end
        if (v0 || v1) begin
          n_vec++;
          if (rq[k].size() == 0 || rq[k][0].cyc != cyc) begin
            n_bad++;
            $display("FAIL unexpected_rdvalid dut%0d cyc %0d: got RdValid0=%b RdValid1=%b, expected none", k, cyc, v0, v1);
          end else begin
            er = rq[k].pop_front();
            if ((v0 && v1) || v1 != (er.m == 1) || (er.chk && rdata_o[k][er.m] !== er.data)) begin
              n_bad++;
              $display("FAIL read dut%0d cyc %0d: got RdValid0=%b RdValid1=%b rdata=%h, need M%0d rdata=%h",
                       k, cyc, v0, v1, rdata_o[k][er.m], er.m, er.data);
            end
          end
        end
      end
    end
  end

  initial begin : driver
    acc_t ea;
    rd_t  er;
    rst  = 1'b1;
    din  = '0;
    cont = 1'b0;
    for (int m = 0; m < 2; m++) begin
      req_i[m]   = 1'b0;
      wen_i[m]   = '0;
      addr_i[m]  = '0;
      wdata_i[m] = '0;
      pend[m]    = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      own[k]  = -1;
      run[k]  = 0;
      last[k] = 1;
      rd_m[k] = -1;
    end
    mx[0] = 8;
    mx[1] = 1;
    for (int i = 0; i < 16; i++) mem[i] = DW'($urandom);

    for (int i = 0; i < 3; i++) step(1'b1, 0);
    cont = 1'b1;
    for (int i = 0; i < 16; i++) step(1'b0, 0);
    cont = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 60);
    for (int i = 0; i < 2500; i++) begin
      if (i < 800)       step($urandom_range(79) == 0, 50);
      else if (i < 1600) step($urandom_range(79) == 0, 95);
      else               step($urandom_range(79) == 0, 20);
    end
    for (int i = 0; i < 2; i++) step(1'b1, 0);
    cont = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 0);
    cont = 1'b0;
    step(1'b1, 0);

    @(negedge clk);
    #1;
    done = 1'b1;
    for (int k = 0; k < 2; k++) begin
      while (aq[k].size() > 0) begin
        ea = aq[k].pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_ack dut%0d cyc %0d: got no ack, expected M%0d ack", k, ea.cyc, ea.m);
      end
      while (rq[k].size() > 0) begin
        er = rq[k].pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_rdvalid dut%0d cyc %0d: got none, expected M%0d RdValid", k, er.cyc, er.m);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
